i2c_reg_sequencer: RTL and testbench

Upstream command sequencer for the I2C master core. Accepts single register-access requests (device address, register address, write data, direction) on a valid/ready port and drives the master's register bus (Addr/DataIn/Wr/DataOut/Int) through the full byte sequence of an I2C register write or read. Returns read data and a status code on a one-cycle response strobe. Sits between a CPU/test FSM and the master top, replacing manual register poking.

---
 rtl/i2c_reg_sequencer_pkg.sv | 73 +++++++
 rtl/i2c_reg_sequencer_if.sv | 43 ++++
 rtl/i2c_reg_sequencer_wdt.sv | 27 ++
 rtl/i2c_reg_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared definitions for the I2C register-access sequencer: master-core
// register map, command/status bit positions, response codes and FSM states.
package i2c_seq_pkg;

    // Master-core register addresses
    localparam logic [2:0] REG_PRESC = 3'd0;
    localparam logic [2:0] REG_CTRL  = 3'd1;
    localparam logic [2:0] REG_TX    = 3'd2;
    localparam logic [2:0] REG_RX    = 3'd3;
    localparam logic [2:0] REG_CMD   = 3'd4;
    localparam logic [2:0] REG_STAT  = 3'd5;

    // CTRL bit
    localparam int unsigned CTRL_EN = 7;

    // CMD bits
    localparam int unsigned CMD_STA  = 7;
    localparam int unsigned CMD_STO  = 6;
    localparam int unsigned CMD_RD   = 5;
    localparam int unsigned CMD_WR   = 4;
    localparam int unsigned CMD_ACK  = 3;
    localparam int unsigned CMD_IACK = 0;

    // STAT bits
    localparam int unsigned STAT_RXACK = 7;
    localparam int unsigned STAT_AL    = 5;
    localparam int unsigned STAT_TIP   = 1;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_AL      = 2'd2,
        ERR_TIMEOUT = 2'd3
    } seq_err_e;

    typedef enum logic [3:0] {
        ST_INIT_PRE = 4'd0,
        ST_INIT_EN  = 4'd1,
        ST_IDLE     = 4'd2,
        ST_LOAD     = 4'd3,
        ST_ISSUE    = 4'd4,
        ST_WAIT     = 4'd5,
        ST_STAT     = 4'd6,
        ST_IACK     = 4'd7,
        ST_RDRX     = 4'd8,
        ST_ABORT    = 4'd9,
        ST_DONE     = 4'd10
    } seq_state_e;

    // One-hot byte with bit 'pos' set
    function automatic logic [7:0] bit_mask(input int unsigned pos);
        logic [7:0] m;
        m = '0;
        m[pos[2:0]] = 1'b1;
        return m;
    endfunction

    // CMD value for byte 'idx' of a write (rw=0) or read (rw=1) transfer.
    // Byte 3 exists only for reads: receive with NACK and stop.
    function automatic logic [7:0] byte_cmd(input logic rw, input logic [1:0] idx);
        logic [7:0] c;
        c = '0;
        case (idx)
            2'd0:    c = bit_mask(CMD_STA) | bit_mask(CMD_WR);
            2'd1:    c = bit_mask(CMD_WR);
            2'd2:    c = rw ? (bit_mask(CMD_STA) | bit_mask(CMD_WR))
                            : (bit_mask(CMD_WR) | bit_mask(CMD_STO));
            default: c = bit_mask(CMD_RD) | bit_mask(CMD_ACK) | bit_mask(CMD_STO);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// Request/response port and master-core register bus of the sequencer.
//
// Handshake: a request transfers on a rising Clk edge where Req_valid and
// Req_ready are both high. The requester holds Req_rw/Req_dev/Req_reg/
// Req_wdata stable while Req_valid is high and not yet accepted. Rsp_valid
// is a one-cycle strobe with no back-pressure; Rsp_rdata/Rsp_err are valid
// in that cycle. BusWr is a single-cycle write strobe qualified by BusAddr
// and BusDataOut; BusDataIn is the combinational read of BusAddr.
interface i2c_reg_sequencer_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
);
    logic              Req_valid;
    logic              Req_ready;
    logic              Req_rw;
    logic [6:0]        Req_dev;
    logic [7:0]        Req_reg;
    logic [7:0]        Req_wdata;
    logic              Rsp_valid;
    logic [7:0]        Rsp_rdata;
    logic [1:0]        Rsp_err;
    logic [AWIDTH-1:0] BusAddr;
    logic [DWIDTH-1:0] BusDataOut;
    logic              BusWr;
    logic [DWIDTH-1:0] BusDataIn;
    logic              BusInt;

    // Environment side: the requester plus the I2C master core
    modport master (
        output Req_valid, Req_rw, Req_dev, Req_reg, Req_wdata,
        input  Req_ready, Rsp_valid, Rsp_rdata, Rsp_err,
        input  BusAddr, BusDataOut, BusWr,
        output BusDataIn, BusInt
    );

    // Sequencer side
    modport slave (
        input  Req_valid, Req_rw, Req_dev, Req_reg, Req_wdata,
        output Req_ready, Rsp_valid, Rsp_rdata, Rsp_err,
        output BusAddr, BusDataOut, BusWr,
        input  BusDataIn, BusInt
    );
endinterface

// File: rtl/i2c_reg_sequencer_wdt.sv
// Loadable down-counter bounding the wait for the master-core interrupt.
// clr loads load_val; en counts down and stops at zero; expired flags zero.
module i2c_seq_wdt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    // Load on clr, otherwise count down while enabled until zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns single register-access requests into the byte-by-byte register
// sequence of the I2C master core and reports read data plus a status code.
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int          DWIDTH   = 8,
    parameter int          AWIDTH   = 3,
    parameter logic [7:0]  PRESCALE = 8'd49,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    i2c_reg_sequencer_if.slave    sif,
    output seq_state_e            dbg_state
);
    seq_state_e state, next_state;

    // Registered request and response
    logic       init_arm;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    seq_err_e   err_q;
    logic [1:0] bidx;

    // Combinational controls
    logic       bus_wr_c;
    logic [2:0] bus_addr_c;
    logic [7:0] bus_dout_c;
    logic       accept;
    logic       err_load;
    seq_err_e   err_d;
    logic       rdata_load;
    logic       bidx_inc;
    logic       wdt_clr;
    logic       wdt_en;
    logic       wdt_expired;

    logic [7:0] bus_din;
    logic [7:0] tx_byte;
    logic [1:0] last_idx;
    logic       is_wr_byte;

    assign bus_din    = sif.BusDataIn[7:0];
    assign last_idx   = rw_q ? 2'd3 : 2'd2;
    // Only the final byte of a read is a receive; all others expect an ACK
    assign is_wr_byte = !(rw_q && (bidx == 2'd3));

    // Data byte loaded into TX for the current byte index
    always_comb begin
        tx_byte = '0;
        case (bidx)
            2'd0:    tx_byte = {dev_q, 1'b0};
            2'd1:    tx_byte = reg_q;
            2'd2:    tx_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
            default: tx_byte = '0;
        endcase
    end

    i2c_seq_wdt #(
        .WIDTH (16)
    ) u_wdt (
        .clk      (Clk),
        .rst      (Rst),
        .clr      (wdt_clr),
        .en       (wdt_en),
        .load_val (TIMEOUT),
        .expired  (wdt_expired)
    );

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_INIT_PRE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, bus outputs and datapath strobes
    always_comb begin
        next_state = state;
        bus_wr_c   = 1'b0;
        bus_addr_c = '0;
        bus_dout_c = '0;
        accept     = 1'b0;
        err_load   = 1'b0;
        err_d      = ERR_OK;
        rdata_load = 1'b0;
        bidx_inc   = 1'b0;
        wdt_clr    = 1'b0;
        wdt_en     = 1'b0;
        case (state)
            ST_INIT_PRE: begin
                // First cycle out of reset drives nothing, so the bus
                // outputs hold their reset values until then
                if (init_arm) begin
                    bus_wr_c   = 1'b1;
                    bus_addr_c = REG_PRESC;
                    bus_dout_c = PRESCALE;
                    next_state = ST_INIT_EN;
                end
            end
            ST_INIT_EN: begin
                bus_wr_c   = 1'b1;
                bus_addr_c = REG_CTRL;
                bus_dout_c = bit_mask(CTRL_EN);
                next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (sif.Req_valid) begin
                    accept     = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus_wr_c   = 1'b1;
                bus_addr_c = REG_TX;
                bus_dout_c = tx_byte;
                next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus_wr_c   = 1'b1;
                bus_addr_c = REG_CMD;
                bus_dout_c = byte_cmd(rw_q, bidx);
                wdt_clr    = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                wdt_en = 1'b1;
                if (sif.BusInt) begin
                    next_state = ST_STAT;
                end else if (wdt_expired) begin
                    err_load   = 1'b1;
                    err_d      = ERR_TIMEOUT;
                    next_state = ST_ABORT;
                end
            end
            ST_STAT: begin
                bus_addr_c = REG_STAT;
                if (bus_din[STAT_AL]) begin
                    // Bus is no longer ours: no STOP, just report
                    err_load   = 1'b1;
                    err_d      = ERR_AL;
                    next_state = ST_DONE;
                end else if (bus_din[STAT_RXACK] && is_wr_byte) begin
                    err_load   = 1'b1;
                    err_d      = ERR_NACK;
                    next_state = ST_ABORT;
                end else begin
                    next_state = ST_IACK;
                end
            end
            ST_IACK: begin
                bus_wr_c   = 1'b1;
                bus_addr_c = REG_CMD;
                bus_dout_c = bit_mask(CMD_IACK);
                if (bidx == last_idx) begin
                    next_state = rw_q ? ST_RDRX : ST_DONE;
                end else begin
                    bidx_inc   = 1'b1;
                    // The receive byte has nothing to load into TX
                    next_state = (rw_q && (bidx == 2'd2)) ? ST_ISSUE : ST_LOAD;
                end
            end
            ST_RDRX: begin
                bus_addr_c = REG_RX;
                rdata_load = 1'b1;
                next_state = ST_DONE;
            end
            ST_ABORT: begin
                bus_wr_c   = 1'b1;
                bus_addr_c = REG_CMD;
                bus_dout_c = bit_mask(CMD_STO) | bit_mask(CMD_IACK);
                next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_INIT_PRE;
            end
        endcase
    end

    // Request capture, byte index and response registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            init_arm <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
            bidx     <= '0;
        end else begin
            init_arm <= 1'b1;
            if (accept) begin
                rw_q    <= sif.Req_rw;
                dev_q   <= sif.Req_dev;
                reg_q   <= sif.Req_reg;
                wdata_q <= sif.Req_wdata;
                rdata_q <= '0;
                err_q   <= ERR_OK;
                bidx    <= '0;
            end else begin
                if (bidx_inc) begin
                    bidx <= bidx + 2'd1;
                end
                if (err_load) begin
                    err_q <= err_d;
                end
                if (rdata_load) begin
                    rdata_q <= bus_din;
                end
            end
        end
    end

    assign sif.Req_ready  = (state == ST_IDLE);
    assign sif.Rsp_valid  = (state == ST_DONE);
    assign sif.Rsp_rdata  = rdata_q;
    assign sif.Rsp_err    = err_q;
    assign sif.BusWr      = bus_wr_c;
    assign sif.BusAddr    = AWIDTH'(bus_addr_c);
    assign sif.BusDataOut = DWIDTH'(bus_dout_c);
    assign dbg_state      = state;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a register-level model of the
// I2C master core and one 7-bit slave (address 0x50) with 256 registers.
module tb_i2c_reg_sequencer;
  import i2c_seq_pkg::*;

  localparam logic [15:0] TB_TIMEOUT = 16'd40;
  localparam logic [6:0]  SLAVE_ADDR = 7'h50;

  logic clk;
  logic rst;
  seq_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  i2c_reg_sequencer_if #(.DWIDTH(8), .AWIDTH(3)) bif ();

  i2c_reg_sequencer #(
    .DWIDTH   (8),
    .AWIDTH   (3),
    .PRESCALE (8'd49),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .sif       (bif.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- master-core + slave model ----------------
  logic [10:0] wr_log[$];
  logic [7:0]  stat_val = 8'h00;
  logic [7:0]  rx_val = 8'h00;
  logic [7:0]  tx_hold = 8'h00;
  logic [7:0]  m_cmd;
  logic [7:0]  sl_ptr = 8'h00;
  logic [7:0]  sl_mem [0:255];
  bit          sl_sel = 0;
  bit          sl_phase = 0;
  bit          bus_busy = 0;
  bit          int_q = 0;
  bit          armed = 0;
  bit          int_stuck = 0;
  int          int_delay = 2;
  int          int_cnt = 0;
  int          cmd_cnt = 0;
  int          al_byte = -1;
  int          sto_cnt = 0;

  assign bif.BusDataIn = (bif.BusAddr == REG_STAT) ? stat_val :
                         ((bif.BusAddr == REG_RX) ? rx_val : 8'h00);
  assign bif.BusInt = int_q;

  always @(negedge clk) begin
    if (armed) begin
      if (int_cnt > 0) int_cnt--;
      if (int_cnt == 0) begin
        int_q = 1'b1;
        armed = 1'b0;
      end
    end
    if (bif.BusWr) begin
      wr_log.push_back({bif.BusAddr, bif.BusDataOut});
      if (bif.BusAddr == REG_TX) tx_hold = bif.BusDataOut;
      if (bif.BusAddr == REG_CMD) begin
        m_cmd = bif.BusDataOut;
        if (m_cmd[CMD_IACK]) int_q = 1'b0;
        if (m_cmd[CMD_STA]) bus_busy = 1'b1;
        if (m_cmd[CMD_WR] || m_cmd[CMD_RD]) begin
          stat_val = 8'h00;
          if (m_cmd[CMD_WR]) begin
            if (m_cmd[CMD_STA]) begin
              sl_sel = (tx_hold[7:1] == SLAVE_ADDR);
              sl_phase = 1'b0;
              if (!sl_sel) stat_val[STAT_RXACK] = 1'b1;
            end else if (!sl_sel) begin
              stat_val[STAT_RXACK] = 1'b1;
            end else if (!sl_phase) begin
              sl_ptr = tx_hold;
              sl_phase = 1'b1;
            end else begin
              sl_mem[sl_ptr] = tx_hold;
              sl_ptr++;
            end
          end else begin
            rx_val = sl_sel ? sl_mem[sl_ptr] : 8'hFF;
          end
          if (cmd_cnt == al_byte) stat_val[STAT_AL] = 1'b1;
          cmd_cnt++;
          int_q = 1'b0;
          armed = 1'b0;
          if (!int_stuck) begin
            if (int_delay == 0) begin
              int_q = 1'b1;
            end else begin
              int_cnt = int_delay;
              armed = 1'b1;
            end
          end
        end
        if (m_cmd[CMD_STO]) begin
          bus_busy = 1'b0;
          sto_cnt++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, output logic [7:0] rd, output logic [1:0] er,
                        output int cyc, output bit got);
    int n;
    got = 0;
    cyc = 0;
    rd = 8'h00;
    er = 2'd0;
    cmd_cnt = 0;
    wr_log.delete();
    @(negedge clk);
    bif.Req_valid = 1'b1;
    bif.Req_rw = rw;
    bif.Req_dev = dev;
    bif.Req_reg = rg;
    bif.Req_wdata = wd;
    n = 0;
    while (!bif.Req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bif.Req_ready) begin
      bif.Req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bif.Req_valid = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      if (bif.Rsp_valid) begin
        got = 1;
        rd = bif.Rsp_rdata;
        er = bif.Rsp_err;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nw;
    int w1_cyc;
    int first_ready;
    logic [10:0] w0;
    logic [10:0] w1;
    rst = 1'b1;
    int_q = 0;
    armed = 0;
    bus_busy = 0;
    repeat (3) @(negedge clk);
    checks++; if (bif.BusWr !== 1'b0) begin errors++; $display("FAIL rst_buswr got %0h exp 0", bif.BusWr); end
    checks++; if (bif.BusAddr !== 3'd0) begin errors++; $display("FAIL rst_busaddr got %0h exp 0", bif.BusAddr); end
    checks++; if (bif.BusDataOut !== 8'h00) begin errors++; $display("FAIL rst_busdout got %0h exp 0", bif.BusDataOut); end
    checks++; if (bif.Req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0h exp 0", bif.Req_ready); end
    checks++; if (bif.Rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0h exp 0", bif.Rsp_valid); end
    checks++; if (bif.Rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rsp_rdata got %0h exp 0", bif.Rsp_rdata); end
    checks++; if (bif.Rsp_err !== 2'd0) begin errors++; $display("FAIL rst_rsp_err got %0h exp 0", bif.Rsp_err); end
    checks++; if (dbg_state !== ST_INIT_PRE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_INIT_PRE); end
    rst = 1'b0;
    nw = 0;
    w1_cyc = -1;
    first_ready = -1;
    w0 = '0;
    w1 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.BusWr) begin
        if (nw == 0) w0 = {bif.BusAddr, bif.BusDataOut};
        if (nw == 1) begin
          w1 = {bif.BusAddr, bif.BusDataOut};
          w1_cyc = i;
        end
        nw++;
      end
      if (bif.Req_ready && first_ready < 0) first_ready = i;
    end
    checks++; if (nw != 2) begin errors++; $display("FAIL init_write_count got %0d exp 2", nw); end
    checks++; if (w0 !== {REG_PRESC, 8'd49}) begin errors++; $display("FAIL init_presc got %0h exp %0h", w0, {REG_PRESC, 8'd49}); end
    checks++; if (w1 !== {REG_CTRL, 8'h80}) begin errors++; $display("FAIL init_ctrl got %0h exp %0h", w1, {REG_CTRL, 8'h80}); end
    checks++; if (first_ready != w1_cyc + 1) begin errors++; $display("FAIL init_ready_cycle got %0d exp %0d", first_ready, w1_cyc + 1); end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    logic [1:0] er;
    int cyc;
    bit got;
    logic [10:0] exp_w [9];
    exp_w = '{{REG_TX, 8'hA0}, {REG_CMD, 8'h90}, {REG_CMD, 8'h01},
              {REG_TX, 8'h10}, {REG_CMD, 8'h10}, {REG_CMD, 8'h01},
              {REG_TX, 8'hA5}, {REG_CMD, 8'h50}, {REG_CMD, 8'h01}};
    int_delay = 2;
    do_req(1'b0, 7'h50, 8'h10, 8'hA5, rd, er, cyc, got);
    checks++; if (!got) begin errors++; $display("FAIL wr_response got none exp strobe"); end
    checks++; if (er !== 2'd0) begin errors++; $display("FAIL wr_err got %0d exp 0", er); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wr_rdata got %0h exp 0", rd); end
    checks++; if (wr_log.size() != 9) begin errors++; $display("FAIL wr_log_size got %0d exp 9", wr_log.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < wr_log.size()) begin
        checks++;
        if (wr_log[i] !== exp_w[i]) begin errors++; $display("FAIL wr_bus_%0d got %0h exp %0h", i, wr_log[i], exp_w[i]); end
      end
    end
    checks++; if (sl_mem[8'h10] !== 8'hA5) begin errors++; $display("FAIL wr_slave_reg got %0h exp a5", sl_mem[8'h10]); end
    @(negedge clk);
    checks++; if (bif.Rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_one_cycle got %0h exp 0", bif.Rsp_valid); end
    checks++; if (bif.Req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after got %0h exp 1", bif.Req_ready); end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    logic [1:0] er;
    int cyc;
    bit got;
    logic [10:0] exp_r [11];
    exp_r = '{{REG_TX, 8'hA0}, {REG_CMD, 8'h90}, {REG_CMD, 8'h01},
              {REG_TX, 8'h10}, {REG_CMD, 8'h10}, {REG_CMD, 8'h01},
              {REG_TX, 8'hA1}, {REG_CMD, 8'h90}, {REG_CMD, 8'h01},
              {REG_CMD, 8'h68}, {REG_CMD, 8'h01}};
    sl_mem[8'h10] = 8'h3C;
    int_delay = 3;
    do_req(1'b1, 7'h50, 8'h10, 8'h00, rd, er, cyc, got);
    checks++; if (!got) begin errors++; $display("FAIL rd_response got none exp strobe"); end
    checks++; if (er !== 2'd0) begin errors++; $display("FAIL rd_err got %0d exp 0", er); end
    checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL rd_rdata got %0h exp 3c", rd); end
    checks++; if (wr_log.size() != 11) begin errors++; $display("FAIL rd_log_size got %0d exp 11", wr_log.size()); end
    for (int i = 0; i < 11; i++) begin
      if (i < wr_log.size()) begin
        checks++;
        if (wr_log[i] !== exp_r[i]) begin errors++; $display("FAIL rd_bus_%0d got %0h exp %0h", i, wr_log[i], exp_r[i]); end
      end
    end
  endtask

  task automatic test_nack();
    logic [7:0] rd;
    logic [1:0] er;
    int cyc;
    bit got;
    int sto0;
    logic [10:0] exp_n [3];
    exp_n = '{{REG_TX, 8'h46}, {REG_CMD, 8'h90}, {REG_CMD, 8'h41}};
    int_delay = 2;
    sto0 = sto_cnt;
    do_req(1'b0, 7'h23, 8'h10, 8'h55, rd, er, cyc, got);
    checks++; if (!got) begin errors++; $display("FAIL nack_response got none exp strobe"); end
    checks++; if (er !== 2'd1) begin errors++; $display("FAIL nack_err got %0d exp 1", er); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL nack_rdata got %0h exp 0", rd); end
    checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL nack_log_size got %0d exp 3", wr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) begin
        checks++;
        if (wr_log[i] !== exp_n[i]) begin errors++; $display("FAIL nack_bus_%0d got %0h exp %0h", i, wr_log[i], exp_n[i]); end
      end
    end
    checks++; if (sto_cnt - sto0 != 1) begin errors++; $display("FAIL nack_sto_count got %0d exp 1", sto_cnt - sto0); end
    checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL nack_bus_idle got %0d exp 0", bus_busy); end
    do_req(1'b0, 7'h50, 8'h20, 8'h77, rd, er, cyc, got);
    checks++; if (!got || er !== 2'd0) begin errors++; $display("FAIL nack_recover got %0d/%0d exp 1/0", got, er); end
    checks++; if (sl_mem[8'h20] !== 8'h77) begin errors++; $display("FAIL nack_recover_reg got %0h exp 77", sl_mem[8'h20]); end
  endtask

  task automatic test_timeout();
    logic [7:0] rd;
    logic [1:0] er;
    int cyc;
    bit got;
    int sto0;
    int_stuck = 1;
    sto0 = sto_cnt;
    do_req(1'b0, 7'h50, 8'h11, 8'h99, rd, er, cyc, got);
    int_stuck = 0;
    checks++; if (!got) begin errors++; $display("FAIL to_response got none exp strobe"); end
    checks++; if (er !== 2'd3) begin errors++; $display("FAIL to_err got %0d exp 3", er); end
    // LOAD + ISSUE + (TIMEOUT+1) WAIT + ABORT + DONE
    checks++; if (cyc != int'(TB_TIMEOUT) + 5) begin errors++; $display("FAIL to_latency got %0d exp %0d", cyc, int'(TB_TIMEOUT) + 5); end
    checks++; if (sto_cnt - sto0 != 1) begin errors++; $display("FAIL to_sto_count got %0d exp 1", sto_cnt - sto0); end
    checks++;
    if (wr_log.size() == 0 || wr_log[wr_log.size() - 1] !== {REG_CMD, 8'h41}) begin
      errors++; $display("FAIL to_abort_cmd got size %0d exp last %0h", wr_log.size(), {REG_CMD, 8'h41});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic [1:0] er;
    int cyc;
    bit got;
    int_delay = 0;
    do_req(1'b0, 7'h50, 8'h30, 8'h11, rd, er, cyc, got);
    checks++; if (!got || er !== 2'd0) begin errors++; $display("FAIL b2b_first got %0d/%0d exp 1/0", got, er); end
    // 3 bytes x (LOAD ISSUE WAIT STAT IACK) + DONE, WAIT left at once
    checks++; if (cyc != 16) begin errors++; $display("FAIL b2b_first_latency got %0d exp 16", cyc); end
    do_req(1'b0, 7'h50, 8'h31, 8'h22, rd, er, cyc, got);
    checks++; if (!got || er !== 2'd0) begin errors++; $display("FAIL b2b_second got %0d/%0d exp 1/0", got, er); end
    checks++; if (cyc != 16) begin errors++; $display("FAIL b2b_second_latency got %0d exp 16", cyc); end
    checks++; if (sl_mem[8'h30] !== 8'h11) begin errors++; $display("FAIL b2b_reg30 got %0h exp 11", sl_mem[8'h30]); end
    checks++; if (sl_mem[8'h31] !== 8'h22) begin errors++; $display("FAIL b2b_reg31 got %0h exp 22", sl_mem[8'h31]); end
    int_delay = 2;
  endtask

  task automatic test_arb_lost();
    logic [7:0] rd;
    logic [1:0] er;
    int cyc;
    bit got;
    int sto0;
    al_byte = 1;
    int_delay = 2;
    sto0 = sto_cnt;
    do_req(1'b0, 7'h50, 8'h12, 8'h44, rd, er, cyc, got);
    al_byte = -1;
    checks++; if (!got) begin errors++; $display("FAIL al_response got none exp strobe"); end
    checks++; if (er !== 2'd2) begin errors++; $display("FAIL al_err got %0d exp 2", er); end
    checks++; if (sto_cnt - sto0 != 0) begin errors++; $display("FAIL al_no_stop got %0d exp 0", sto_cnt - sto0); end
    checks++; if (wr_log.size() != 5) begin errors++; $display("FAIL al_log_size got %0d exp 5", wr_log.size()); end
    @(negedge clk);
    checks++; if (bif.Rsp_valid !== 1'b0) begin errors++; $display("FAIL al_rsp_one_cycle got %0h exp 0", bif.Rsp_valid); end
    checks++; if (bif.Req_ready !== 1'b1) begin errors++; $display("FAIL al_ready_after got %0h exp 1", bif.Req_ready); end
  endtask

  initial begin
    rst = 1'b1;
    bif.Req_valid = 1'b0;
    bif.Req_rw = 1'b0;
    bif.Req_dev = '0;
    bif.Req_reg = '0;
    bif.Req_wdata = '0;
    for (int i = 0; i < 256; i++) sl_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_arb_lost();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached exp finish");
    $fatal(1, "time limit");
  end
endmodule
